// File: rtl/eyeriss_pe_pkg.sv
// Shared definitions for the multi-channel Eyeriss-style processing element:
// controller states and default sizing constants.
package eyeriss_pe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        PSUM,
        EMIT
    } pe_state_e;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_MAX_FIL = 16;
    localparam int DEF_MAX_MAP = 16;
    localparam int DEF_MAX_CH  = 4;
    localparam int DEF_ID_W    = 8;

endpackage

// File: rtl/eyeriss_pe_multich_mac.sv
// Datapath of the PE: signed multiply-accumulate, arithmetic right shift after
// the last tap, optional psum add, and saturation of the next accumulator value.
module eyeriss_mac_unit
    import eyeriss_pe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ACC_W   = 2 * DEF_DATA_W + 6,
    parameter int SHIFT_W = $clog2(2 * DEF_DATA_W)
) (
    input  logic               CLK,
    input  logic               clr,
    input  logic               clear,
    input  logic               mac_en,
    input  logic               mac_last,
    input  logic               add_en,
    input  logic [DATA_W-1:0]  fil_val,
    input  logic [DATA_W-1:0]  map_val,
    input  logic [DATA_W-1:0]  add_val,
    input  logic [SHIFT_W-1:0] shift,
    output logic [DATA_W-1:0]  result
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    add_ext;
    logic signed [ACC_W-1:0]    sum;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    assign prod     = $signed(fil_val) * $signed(map_val);
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign add_ext  = {{(ACC_W-DATA_W){add_val[DATA_W-1]}}, add_val};
    assign sum      = acc_q + prod_ext;

    // The shift is folded into the final accumulation so the result is ready
    // on the same edge the controller leaves the MAC phase.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (mac_en) begin
            acc_d = mac_last ? (sum >>> shift) : sum;
        end else if (add_en) begin
            acc_d = acc_q + add_ext;
        end
    end

    always_comb begin
        if (acc_d > SAT_MAX) begin
            result = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (acc_d < SAT_MIN) begin
            result = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            result = acc_d[DATA_W-1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/eyeriss_pe_multich.sv
// Multi-channel 1-D convolution PE: id-filtered filter/map scratchpad load,
// channel-major MAC sweep per output position, optional psum add, handshaked emit.
module eyeriss_pe_multich
    import eyeriss_pe_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_FIL = DEF_MAX_FIL,
    parameter int MAX_MAP = DEF_MAX_MAP,
    parameter int MAX_CH  = DEF_MAX_CH,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic                          CLK,
    input  logic                          clr,
    input  logic                          cfg_valid,
    input  logic [$clog2(MAX_FIL):0]      cfg_fil_len,
    input  logic [$clog2(MAX_MAP):0]      cfg_map_len,
    input  logic [$clog2(MAX_CH):0]       cfg_ch,
    input  logic [ID_W-1:0]               cfg_id,
    input  logic                          cfg_psum_en,
    input  logic [$clog2(2*DATA_W)-1:0]   cfg_shift,
    input  logic [ID_W-1:0]               id_in,
    input  logic [DATA_W-1:0]             fil_data,
    input  logic                          fil_valid,
    output logic                          fil_ready,
    input  logic [DATA_W-1:0]             map_data,
    input  logic                          map_valid,
    output logic                          map_ready,
    input  logic [DATA_W-1:0]             psum_in_data,
    input  logic                          psum_in_valid,
    output logic                          psum_in_ready,
    output logic [DATA_W-1:0]             psum_out_data,
    output logic                          psum_out_valid,
    input  logic                          psum_out_ready,
    output logic                          busy,
    output logic                          cfg_err
);

    localparam int FIL_LEN_W = $clog2(MAX_FIL) + 1;
    localparam int MAP_LEN_W = $clog2(MAX_MAP) + 1;
    localparam int CH_W      = $clog2(MAX_CH) + 1;
    localparam int SHIFT_W   = $clog2(2 * DATA_W);
    localparam int FIL_DEPTH = MAX_FIL * MAX_CH;
    localparam int MAP_DEPTH = MAX_MAP * MAX_CH;
    localparam int FA_W      = $clog2(FIL_DEPTH);
    localparam int MA_W      = $clog2(MAP_DEPTH);
    localparam int FC_W      = FA_W + 1;
    localparam int MC_W      = MA_W + 1;
    localparam int ACC_W     = 2 * DATA_W + $clog2(MAX_FIL * MAX_CH);

    pe_state_e             state_q, state_d;
    logic [FIL_LEN_W-1:0]  fil_len_q, fil_len_d, k_q, k_d;
    logic [MAP_LEN_W-1:0]  map_len_q, map_len_d, o_q, o_d;
    logic [CH_W-1:0]       ch_q, ch_d, c_q, c_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic                  psum_en_q, psum_en_d;
    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [FC_W-1:0]       fil_cnt_q, fil_cnt_d;
    logic [MC_W-1:0]       map_cnt_q, map_cnt_d;
    logic                  fil_ready_q, fil_ready_d, map_ready_q, map_ready_d;
    logic                  psum_in_ready_q, psum_in_ready_d;
    logic                  psum_out_valid_q, psum_out_valid_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [DATA_W-1:0]     out_data_q, out_data_d;

    logic [DATA_W-1:0]     fil_mem [FIL_DEPTH];
    logic [DATA_W-1:0]     map_mem [MAP_DEPTH];
    logic [FA_W-1:0]       fil_addr;
    logic [MA_W-1:0]       map_addr;
    logic                  fil_fire, map_fire, cfg_bad;
    logic                  mac_en, mac_last, acc_clear, acc_add;
    logic [DATA_W-1:0]     mac_result;

    assign cfg_bad = (cfg_fil_len == '0) || (cfg_fil_len > FIL_LEN_W'(MAX_FIL)) ||
                     (cfg_map_len == '0) || (cfg_map_len > MAP_LEN_W'(MAX_MAP)) ||
                     (cfg_ch == '0) || (cfg_ch > CH_W'(MAX_CH)) ||
                     (cfg_fil_len > cfg_map_len);

    assign fil_fire = fil_valid && fil_ready_q && (id_in == id_q);
    assign map_fire = map_valid && map_ready_q && (id_in == id_q);
    assign fil_addr = FA_W'(c_q) * FA_W'(fil_len_q) + FA_W'(k_q);
    assign map_addr = MA_W'(c_q) * MA_W'(map_len_q) + MA_W'(o_q) + MA_W'(k_q);

    always_comb begin
        state_d    = state_q;
        fil_len_d  = fil_len_q;
        map_len_d  = map_len_q;
        ch_d       = ch_q;
        id_d       = id_q;
        psum_en_d  = psum_en_q;
        shift_d    = shift_q;
        fil_cnt_d  = fil_cnt_q;
        map_cnt_d  = map_cnt_q;
        k_d        = k_q;
        c_d        = c_q;
        o_d        = o_q;
        out_data_d = out_data_q;
        cfg_err_d  = 1'b0;
        mac_en     = 1'b0;
        mac_last   = 1'b0;
        acc_clear  = 1'b0;
        acc_add    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid && cfg_bad) begin
                    cfg_err_d = 1'b1;
                end else if (cfg_valid) begin
                    state_d   = LOAD;
                    fil_len_d = cfg_fil_len;
                    map_len_d = cfg_map_len;
                    ch_d      = cfg_ch;
                    id_d      = cfg_id;
                    psum_en_d = cfg_psum_en;
                    shift_d   = cfg_shift;
                    fil_cnt_d = '0;
                    map_cnt_d = '0;
                    k_d       = '0;
                    c_d       = '0;
                    o_d       = '0;
                end
            end
            LOAD: begin
                if (fil_fire) fil_cnt_d = fil_cnt_q + 1'b1;
                if (map_fire) map_cnt_d = map_cnt_q + 1'b1;
                if ((fil_cnt_q == FC_W'(fil_len_q) * FC_W'(ch_q)) &&
                    (map_cnt_q == MC_W'(map_len_q) * MC_W'(ch_q))) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                // Taps sweep innermost; the channel advances when a tap row wraps.
                if (k_q == fil_len_q - 1'b1) begin
                    k_d = '0;
                    if (c_q == ch_q - 1'b1) begin
                        c_d        = '0;
                        mac_last   = 1'b1;
                        state_d    = psum_en_q ? PSUM : EMIT;
                        out_data_d = mac_result;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            PSUM: begin
                if (psum_in_valid && psum_in_ready_q) begin
                    acc_add    = 1'b1;
                    state_d    = EMIT;
                    out_data_d = mac_result;
                end
            end
            EMIT: begin
                if (psum_out_ready && psum_out_valid_q) begin
                    acc_clear = 1'b1;
                    if (o_q == map_len_q - fil_len_q) begin
                        o_d     = '0;
                        state_d = IDLE;
                    end else begin
                        o_d     = o_q + 1'b1;
                        state_d = MAC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        fil_ready_d      = (state_d == LOAD) && (fil_cnt_d < FC_W'(fil_len_d) * FC_W'(ch_d));
        map_ready_d      = (state_d == LOAD) && (map_cnt_d < MC_W'(map_len_d) * MC_W'(ch_d));
        psum_in_ready_d  = (state_d == PSUM);
        psum_out_valid_d = (state_d == EMIT);
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            state_q          <= IDLE;
            fil_len_q        <= '0;
            map_len_q        <= '0;
            ch_q             <= '0;
            id_q             <= '0;
            psum_en_q        <= 1'b0;
            shift_q          <= '0;
            fil_cnt_q        <= '0;
            map_cnt_q        <= '0;
            k_q              <= '0;
            c_q              <= '0;
            o_q              <= '0;
            out_data_q       <= '0;
            cfg_err_q        <= 1'b0;
            fil_ready_q      <= 1'b0;
            map_ready_q      <= 1'b0;
            psum_in_ready_q  <= 1'b0;
            psum_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            fil_len_q        <= fil_len_d;
            map_len_q        <= map_len_d;
            ch_q             <= ch_d;
            id_q             <= id_d;
            psum_en_q        <= psum_en_d;
            shift_q          <= shift_d;
            fil_cnt_q        <= fil_cnt_d;
            map_cnt_q        <= map_cnt_d;
            k_q              <= k_d;
            c_q              <= c_d;
            o_q              <= o_d;
            out_data_q       <= out_data_d;
            cfg_err_q        <= cfg_err_d;
            fil_ready_q      <= fil_ready_d;
            map_ready_q      <= map_ready_d;
            psum_in_ready_q  <= psum_in_ready_d;
            psum_out_valid_q <= psum_out_valid_d;
        end
    end

    // Scratchpads arrive channel-major, so the running count is the address.
    always_ff @(posedge CLK) begin
        if (!clr && fil_fire) fil_mem[fil_cnt_q[FA_W-1:0]] <= fil_data;
        if (!clr && map_fire) map_mem[map_cnt_q[MA_W-1:0]] <= map_data;
    end

    eyeriss_mac_unit #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .SHIFT_W (SHIFT_W)
    ) u_mac (
        .CLK      (CLK),
        .clr      (clr),
        .clear    (acc_clear),
        .mac_en   (mac_en),
        .mac_last (mac_last),
        .add_en   (acc_add),
        .fil_val  (fil_mem[fil_addr]),
        .map_val  (map_mem[map_addr]),
        .add_val  (psum_in_data),
        .shift    (shift_q),
        .result   (mac_result)
    );

    assign fil_ready      = fil_ready_q;
    assign map_ready      = map_ready_q;
    assign psum_in_ready  = psum_in_ready_q;
    assign psum_out_valid = psum_out_valid_q;
    assign psum_out_data  = out_data_q;
    assign cfg_err        = cfg_err_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_eyeriss_pe_multich.sv
// Directed bench for eyeriss_pe_multich: hand-computed convolution vectors,
// psum and backpressure stalls, config errors, id filtering and mid-MAC reset.
module tb_eyeriss_pe_multich;

    localparam logic [7:0] PE_ID  = 8'h3C;
    localparam logic [7:0] BAD_ID = 8'h55;

    logic        CLK = 1'b0;
    logic        clr;
    logic        cfg_valid;
    logic [4:0]  cfg_fil_len;
    logic [4:0]  cfg_map_len;
    logic [2:0]  cfg_ch;
    logic [7:0]  cfg_id;
    logic        cfg_psum_en;
    logic [4:0]  cfg_shift;
    logic [7:0]  id_in;
    logic [15:0] fil_data;
    logic        fil_valid;
    logic        fil_ready;
    logic [15:0] map_data;
    logic        map_valid;
    logic        map_ready;
    logic [15:0] psum_in_data;
    logic        psum_in_valid;
    logic        psum_in_ready;
    logic [15:0] psum_out_data;
    logic        psum_out_valid;
    logic        psum_out_ready;
    logic        busy;
    logic        cfg_err;

    int vecCount = 0;
    int errCount = 0;
    int filVec[64];
    int mapVec[64];
    int psumVec[16];
    int expVec[16];

    always #5 CLK = ~CLK;

    eyeriss_pe_multich dut (
        .CLK            (CLK),
        .clr            (clr),
        .cfg_valid      (cfg_valid),
        .cfg_fil_len    (cfg_fil_len),
        .cfg_map_len    (cfg_map_len),
        .cfg_ch         (cfg_ch),
        .cfg_id         (cfg_id),
        .cfg_psum_en    (cfg_psum_en),
        .cfg_shift      (cfg_shift),
        .id_in          (id_in),
        .fil_data       (fil_data),
        .fil_valid      (fil_valid),
        .fil_ready      (fil_ready),
        .map_data       (map_data),
        .map_valid      (map_valid),
        .map_ready      (map_ready),
        .psum_in_data   (psum_in_data),
        .psum_in_valid  (psum_in_valid),
        .psum_in_ready  (psum_in_ready),
        .psum_out_data  (psum_out_data),
        .psum_out_valid (psum_out_valid),
        .psum_out_ready (psum_out_ready),
        .busy           (busy),
        .cfg_err        (cfg_err)
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        vecCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic configure(input int fl, input int ml, input int ch, input int ps, input int sh);
        cfg_fil_len = 5'(fl);
        cfg_map_len = 5'(ml);
        cfg_ch      = 3'(ch);
        cfg_id      = PE_ID;
        cfg_psum_en = ps[0];
        cfg_shift   = 5'(sh);
        cfg_valid   = 1'b1;
        @(negedge CLK);
        cfg_valid   = 1'b0;
    endtask

    task automatic sendWord(input bit isMap, input int d);
        int n = 0;
        id_in = PE_ID;
        if (isMap) begin
            map_data  = 16'(d);
            map_valid = 1'b1;
        end else begin
            fil_data  = 16'(d);
            fil_valid = 1'b1;
        end
        while (((isMap ? map_ready : fil_ready) !== 1'b1) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checkOutput(isMap ? "map_ready_wait" : "fil_ready_wait", int'(n < 50), 1);
        @(negedge CLK);
        map_valid = 1'b0;
        fil_valid = 1'b0;
    endtask

    task automatic sendJunk(input bit isMap);
        id_in = BAD_ID;
        if (isMap) begin
            map_data  = 16'd999;
            map_valid = 1'b1;
        end else begin
            fil_data  = 16'd777;
            fil_valid = 1'b1;
        end
        @(negedge CLK);
        map_valid = 1'b0;
        fil_valid = 1'b0;
        id_in     = PE_ID;
    endtask

    task automatic applyStimulus(input int filLen, input int mapLen, input int chN,
                                 input int psumEn, input int shiftAmt, input int psumDelay,
                                 input int readyDelay, input bit junk);
        int n;
        int got;
        bit ok;
        configure(filLen, mapLen, chN, psumEn, shiftAmt);
        checkOutput("cfg_busy", int'(busy), 1);
        checkOutput("cfg_err_legal", int'(cfg_err), 0);
        cfg_fil_len = 5'd0;
        cfg_valid   = 1'b1;
        @(negedge CLK);
        cfg_valid   = 1'b0;
        checkOutput("cfg_ignored_err", int'(cfg_err), 0);
        checkOutput("cfg_ignored_busy", int'(busy), 1);
        if (junk) sendJunk(1'b0);
        for (int i = 0; i < filLen * chN; i++) sendWord(1'b0, filVec[i]);
        if (junk) sendJunk(1'b1);
        for (int i = 0; i < mapLen * chN; i++) sendWord(1'b1, mapVec[i]);
        for (int o = 0; o <= mapLen - filLen; o++) begin
            if (psumEn != 0) begin
                n = 0;
                while (psum_in_ready !== 1'b1 && n < 200) begin
                    @(negedge CLK);
                    n++;
                end
                checkOutput("psum_ready_wait", int'(n < 200), 1);
                if (psumDelay > 0) begin
                    ok = 1'b1;
                    for (int d = 0; d < psumDelay; d++) begin
                        @(negedge CLK);
                        if (psum_out_valid !== 1'b0 || psum_in_ready !== 1'b1) ok = 1'b0;
                    end
                    checkOutput("psum_hold", int'(ok), 1);
                end
                psum_in_data  = 16'(psumVec[o]);
                psum_in_valid = 1'b1;
                @(negedge CLK);
                psum_in_valid = 1'b0;
            end
            n = 0;
            while (psum_out_valid !== 1'b1 && n < 200) begin
                @(negedge CLK);
                n++;
            end
            checkOutput("out_valid_wait", int'(n < 200), 1);
            if (psumEn == 0 && o > 0) checkOutput("mac_cycles", n, filLen * chN);
            got = int'($signed(psum_out_data));
            checkOutput("out_data", got, expVec[o]);
            if (readyDelay > 0) begin
                ok = 1'b1;
                for (int d = 0; d < readyDelay; d++) begin
                    @(negedge CLK);
                    got = int'($signed(psum_out_data));
                    if (psum_out_valid !== 1'b1 || got != expVec[o]) ok = 1'b0;
                end
                checkOutput("out_stable", int'(ok), 1);
            end
            psum_out_ready = 1'b1;
            @(negedge CLK);
            psum_out_ready = 1'b0;
        end
        checkOutput("idle_after", int'(busy), 0);
        checkOutput("valid_after", int'(psum_out_valid), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clr = 1'b1; cfg_valid = 1'b0; cfg_fil_len = '0; cfg_map_len = '0; cfg_ch = '0;
        cfg_id = '0; cfg_psum_en = 1'b0; cfg_shift = '0; id_in = '0;
        fil_data = '0; fil_valid = 1'b0; map_data = '0; map_valid = 1'b0;
        psum_in_data = '0; psum_in_valid = 1'b0; psum_out_ready = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_fil_ready", int'(fil_ready), 0);
        checkOutput("rst_map_ready", int'(map_ready), 0);
        checkOutput("rst_psum_in_ready", int'(psum_in_ready), 0);
        checkOutput("rst_out_valid", int'(psum_out_valid), 0);
        checkOutput("rst_out_data", int'(psum_out_data), 0);
        checkOutput("rst_cfg_err", int'(cfg_err), 0);
        clr = 1'b0;
        @(negedge CLK);

        // 3-tap filter over a 5-word map, with wrong-id words and a stalled consumer.
        filVec[0:2] = '{1, 2, 3};
        mapVec[0:4] = '{1, 2, 3, 4, 5};
        expVec[0:2] = '{14, 20, 26};
        applyStimulus(3, 5, 1, 0, 0, 0, 5, 1'b1);

        // Same convolution plus incoming partial sums arriving late.
        psumVec[0:2] = '{100, 200, 300};
        expVec[0:2]  = '{114, 220, 326};
        applyStimulus(3, 5, 1, 1, 0, 4, 0, 1'b0);

        // Two channels: fil ch0 {1,1} ch1 {2,2}; map ch0 {1,2,3} ch1 {1,1,1}.
        filVec[0:3] = '{1, 1, 2, 2};
        mapVec[0:5] = '{1, 2, 3, 1, 1, 1};
        expVec[0:1] = '{7, 9};
        applyStimulus(2, 3, 2, 0, 0, 0, 0, 1'b0);

        // Arithmetic shift by one on the first data set.
        filVec[0:2] = '{1, 2, 3};
        mapVec[0:4] = '{1, 2, 3, 4, 5};
        expVec[0:2] = '{7, 10, 13};
        applyStimulus(3, 5, 1, 0, 1, 0, 0, 1'b0);

        // Illegal configuration: filter longer than map.
        configure(4, 3, 1, 0, 0);
        checkOutput("cfg_err_pulse", int'(cfg_err), 1);
        checkOutput("cfg_err_busy", int'(busy), 0);
        @(negedge CLK);
        checkOutput("cfg_err_clear", int'(cfg_err), 0);
        checkOutput("cfg_err_no_load", int'(fil_ready), 0);

        // Reset while the MAC sweep is in progress.
        configure(4, 4, 2, 0, 0);
        for (int i = 0; i < 8; i++) sendWord(1'b0, 1);
        for (int i = 0; i < 8; i++) sendWord(1'b1, 1);
        repeat (3) @(negedge CLK);
        checkOutput("mac_busy", int'(busy), 1);
        clr = 1'b1;
        @(negedge CLK);
        clr = 1'b0;
        checkOutput("clr_busy", int'(busy), 0);
        checkOutput("clr_out_valid", int'(psum_out_valid), 0);
        checkOutput("clr_out_data", int'(psum_out_data), 0);
        checkOutput("clr_fil_ready", int'(fil_ready), 0);
        checkOutput("clr_map_ready", int'(map_ready), 0);
        checkOutput("clr_psum_in_ready", int'(psum_in_ready), 0);
        @(negedge CLK);

        // Saturation at both ends of the signed 16-bit range.
        filVec[0] = 32767;
        mapVec[0] = 32767;
        expVec[0] = 32767;
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 1'b0);
        filVec[0] = -32768;
        mapVec[0] = 32767;
        expVec[0] = -32768;
        applyStimulus(1, 1, 1, 0, 0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/eyeriss_pe_multich.md
EYERISS_PE_MULTICH -- requirements
Module: eyeriss_pe_multich

Interface
REQ-001 SHALL have parameters: DATA_W, default 16, operand/psum width (signed); MAX_FIL, default 16, max filter taps per channel; MAX_MAP, default 16, max map words per channel; MAX_CH, default 4, max input channels; ID_W, default 8, multicast id width.
REQ-002 SHALL have ports:
CLK  in  1  sole clock, rising edge
clr  in  1  synchronous active-high reset
cfg_valid  in  1  configuration strobe, accepted only in IDLE
cfg_fil_len  in  clog2(MAX_FIL)+1  taps per channel, 1..MAX_FIL
cfg_map_len  in  clog2(MAX_MAP)+1  map words per channel, 1..MAX_MAP
cfg_ch  in  clog2(MAX_CH)+1  channel count, 1..MAX_CH
cfg_id  in  ID_W  PE id
cfg_psum_en  in  1  add incoming psum to each output
cfg_shift  in  clog2(2*DATA_W)  arithmetic right shift of accumulator
id_in  in  ID_W  id tag on fil/map buses
fil_data/fil_valid/fil_ready  in/in/out  DATA_W/1/1  filter load handshake
map_data/map_valid/map_ready  in/in/out  DATA_W/1/1  map load handshake
psum_in_data/psum_in_valid/psum_in_ready  in/in/out  DATA_W/1/1  incoming psum
psum_out_data/psum_out_valid/psum_out_ready  out/out/in  DATA_W/1/1  result
busy  out  1  not IDLE
cfg_err  out  1  one-cycle pulse on illegal config

Function
REQ-003 SHALL use states IDLE, LOAD, MAC, PSUM, EMIT; IDLE->LOAD on cfg_valid with legal config, latching all cfg_* fields.
REQ-004 SHALL treat config illegal if any length is 0, exceeds its maximum, or cfg_fil_len > cfg_map_len; pulse cfg_err one cycle, stay IDLE.
REQ-005 In LOAD, fil_ready SHALL be high while filter count < fil_len*ch, map_ready while map count < map_len*ch; transfer occurs on valid && ready && id_in==cfg_id; words stored channel-major (index ch*len+i).
REQ-006 Non-matching id_in words SHALL be ignored without stall; LOAD->MAC when both counts complete.
REQ-007 MAC SHALL perform one signed DATA_W×DATA_W multiply per cycle, iterating tap k inner, channel outer, accumulating fil[c][k]*map[c][o+k] into accumulator of width 2*DATA_W+clog2(MAX_FIL*MAX_CH); MAC lasts exactly fil_len*ch cycles per output position o.
REQ-008 After MAC: shift accumulator right arithmetically by cfg_shift; go to PSUM if cfg_psum_en else EMIT.
REQ-009 PSUM SHALL assert psum_in_ready, wait indefinitely for psum_in_valid, add sign-extended psum_in_data on handshake, then EMIT.
REQ-010 Result SHALL saturate to signed DATA_W range before output.
REQ-011 EMIT SHALL hold psum_out_valid and stable psum_out_data until psum_out_ready; on handshake clear accumulator, o++, next MAC, or IDLE after o = map_len-fil_len.
REQ-012 Outputs per configuration SHALL equal map_len-fil_len+1; cfg_valid outside IDLE SHALL be ignored.

Reset
REQ-013 On clr at any cycle: state IDLE, counters/accumulator 0, all ready/valid outputs 0, psum_out_data 0, busy 0, cfg_err 0; scratchpad contents need not be cleared; in-flight work discarded.

Structure
REQ-014 Shared package eyeriss_pe_pkg SHALL hold the state enum and default parameter constants.
REQ-015 Multiply/accumulate/shift/saturate SHALL be sub-module eyeriss_mac_unit; scratchpads and FSM stay in top.

Verification
REQ-016 fil_len3 ch1 map_len5, fil {1,2,3}, map {1,2,3,4,5}, psum off, shift0 -> outputs 14,20,26 then IDLE.
REQ-017 Same plus psum_en, psum_in 100,200,300 -> 114,220,326; psum_in_valid delayed 4 cycles -> no output until handshake.
REQ-018 ch2 fil_len2 map_len3, fil {1,1,2,2}, map {1,2,3,1,1,1} -> 7,9; each MAC phase 4 cycles.
REQ-019 fil 32767 map 32767 len1 -> 32767; fil -32768 map 32767 -> -32768; fil_len4 map_len3 -> cfg_err pulse, no loading.
REQ-020 psum_out_ready low 5 cycles -> data stable, no loss; words with wrong id_in skipped; clr mid-MAC -> IDLE next cycle, all outputs 0.
